// File: rtl/lfo_ctrl_if.sv
// Handshake and settings bundle between lfo_ctrl (master) and the LFO sample engine (slave).
interface lfo_ctrl_if;
    logic       fifoUpdate;
    logic       lfoReset;
    logic       newValFlag;
    logic [3:0] lfoFreq;
    logic [3:0] lfoScale;

    modport master (
        output fifoUpdate, lfoReset, lfoFreq, lfoScale,
        input  newValFlag
    );

    modport slave (
        input  fifoUpdate, lfoReset, lfoFreq, lfoScale,
        output newValFlag
    );
endinterface

// File: rtl/lfo_ctrl.sv
// LFO sequencer: sample-rate strobe, acknowledge timeout and sample-boundary parameter updates.
// Define LFO_CTRL_GLIDE_EN to step lfoFreq/lfoScale toward their targets instead of loading them.
module lfo_ctrl #(
    parameter int unsigned TICK_DIV    = 136,
    parameter int unsigned GLIDE_TICKS = 64,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic       clk,
    input  logic       resetN,
    input  logic       enable,
    input  logic [3:0] freqTarget,
    input  logic [3:0] scaleTarget,
    input  logic       clrErr,
    output logic       busy,
    output logic       ackErr,
    output logic       sampleValid,
    lfo_ctrl_if.master lfo
);
    localparam int unsigned TW = $clog2(TICK_DIV);
    localparam int unsigned AW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [AW-1:0] ACK_LAST  = AW'(ACK_TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, INIT, RUN, WAIT_ACK} state_t;

    state_t          state_q, state_d;
    logic [1:0]      init_cnt_q, init_cnt_d;
    logic [TW-1:0]   tick_q, tick_d;
    logic [AW-1:0]   ack_tmr_q, ack_tmr_d;
    logic [3:0]      freq_q, freq_d, scale_q, scale_d;
    logic            ack_err_q, ack_err_d;
    logic            valid_q, valid_d;
    logic            en_meta_q, en_meta_d, en_sync_q, en_sync_d;
    logic [3:0]      ft_meta_q, ft_meta_d, ft_sync_q, ft_sync_d;
    logic [3:0]      st_meta_q, st_meta_d, st_sync_q, st_sync_d;
    logic            strobe, sample_done, err_set;
    logic [TW-1:0]   tick_next;

`ifdef LFO_CTRL_GLIDE_EN
    localparam int unsigned GW = $clog2(GLIDE_TICKS + 1);
    localparam logic [GW-1:0] GLIDE_LAST = GW'(GLIDE_TICKS - 1);
    logic [GW-1:0] glide_q, glide_d;

    function automatic logic [3:0] step_toward(input logic [3:0] cur, input logic [3:0] tgt);
        if (cur < tgt)      return cur + 4'd1;
        else if (cur > tgt) return cur - 4'd1;
        else                return cur;
    endfunction
`endif

    assign tick_next = (tick_q == TICK_LAST) ? '0 : tick_q + TW'(1);
    assign strobe    = (state_q == RUN) && en_sync_q && (tick_q == TICK_LAST);

    always_comb begin
        state_d     = state_q;
        init_cnt_d  = init_cnt_q;
        tick_d      = tick_q;
        ack_tmr_d   = ack_tmr_q;
        freq_d      = freq_q;
        scale_d     = scale_q;
        valid_d     = 1'b0;
        sample_done = 1'b0;
        err_set     = 1'b0;
        en_meta_d   = enable;
        en_sync_d   = en_meta_q;
        ft_meta_d   = freqTarget;
        ft_sync_d   = ft_meta_q;
        st_meta_d   = scaleTarget;
        st_sync_d   = st_meta_q;
`ifdef LFO_CTRL_GLIDE_EN
        glide_d     = glide_q;
`endif

        unique case (state_q)
            IDLE: begin
                tick_d     = '0;
                init_cnt_d = '0;
                if (en_sync_q) state_d = INIT;
            end
            INIT: begin
                tick_d     = '0;
                init_cnt_d = init_cnt_q + 2'd1;
                if (init_cnt_q == 2'd0) begin
                    freq_d  = ft_sync_q;
                    scale_d = st_sync_q;
                end
                if (init_cnt_q == 2'd3) state_d = RUN;
            end
            RUN: begin
                tick_d = tick_next;
                if (!en_sync_q) begin
                    state_d = IDLE;
                    tick_d  = '0;
                end else if (strobe) begin
                    state_d   = WAIT_ACK;
                    ack_tmr_d = '0;
                end
            end
            WAIT_ACK: begin
                tick_d    = tick_next;
                ack_tmr_d = ack_tmr_q + AW'(1);
                if (lfo.newValFlag) begin
                    valid_d     = 1'b1;
                    sample_done = 1'b1;
                end else if (ack_tmr_q == ACK_LAST) begin
                    err_set     = 1'b1;
                    sample_done = 1'b1;
                end
                // A disable seen here only takes effect once the pending sample resolves.
                if (sample_done) begin
                    state_d = en_sync_q ? RUN : IDLE;
                    if (!en_sync_q) tick_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase

`ifdef LFO_CTRL_GLIDE_EN
        // Glide counter rests at 0 while settled so each new target gets a full interval per step.
        if (freq_q == ft_sync_q && scale_q == st_sync_q) begin
            glide_d = '0;
        end else if (sample_done) begin
            if (glide_q == GLIDE_LAST) begin
                glide_d = '0;
                freq_d  = step_toward(freq_q, ft_sync_q);
                scale_d = step_toward(scale_q, st_sync_q);
            end else begin
                glide_d = glide_q + GW'(1);
            end
        end
`else
        if (sample_done) begin
            freq_d  = ft_sync_q;
            scale_d = st_sync_q;
        end
`endif

        ack_err_d = err_set | (ack_err_q & ~clrErr);
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q    <= IDLE;
            init_cnt_q <= '0;
            tick_q     <= '0;
            ack_tmr_q  <= '0;
            freq_q     <= '0;
            scale_q    <= '0;
            ack_err_q  <= 1'b0;
            valid_q    <= 1'b0;
            en_meta_q  <= 1'b0;
            en_sync_q  <= 1'b0;
            ft_meta_q  <= '0;
            ft_sync_q  <= '0;
            st_meta_q  <= '0;
            st_sync_q  <= '0;
`ifdef LFO_CTRL_GLIDE_EN
            glide_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            tick_q     <= tick_d;
            ack_tmr_q  <= ack_tmr_d;
            freq_q     <= freq_d;
            scale_q    <= scale_d;
            ack_err_q  <= ack_err_d;
            valid_q    <= valid_d;
            en_meta_q  <= en_meta_d;
            en_sync_q  <= en_sync_d;
            ft_meta_q  <= ft_meta_d;
            ft_sync_q  <= ft_sync_d;
            st_meta_q  <= st_meta_d;
            st_sync_q  <= st_sync_d;
`ifdef LFO_CTRL_GLIDE_EN
            glide_q    <= glide_d;
`endif
        end
    end

    assign lfo.fifoUpdate = strobe;
    assign lfo.lfoReset   = !((state_q == RUN) || (state_q == WAIT_ACK));
    assign lfo.lfoFreq    = freq_q;
    assign lfo.lfoScale   = scale_q;
    assign ackErr         = ack_err_q;
    assign sampleValid    = valid_q;
`ifdef LFO_CTRL_GLIDE_EN
    assign busy = (freq_q != ft_sync_q) || (scale_q != st_sync_q);
`else
    assign busy = 1'b0;
`endif
endmodule

// File: tb/tb_lfo_ctrl.sv
// Self-checking bench for lfo_ctrl: strobe timing, ack/timeout, parameter updates, enable/reset.
module tb_lfo_ctrl;
    localparam int TD = 136;
    localparam int GT = 4;
    localparam int AT = 8;

    logic       clk = 1'b0;
    logic       resetN, enable, clrErr;
    logic [3:0] freqTarget, scaleTarget;
    logic       busy, ackErr, sampleValid;

    lfo_ctrl_if bus();

    lfo_ctrl #(.TICK_DIV(TD), .GLIDE_TICKS(GT), .ACK_TIMEOUT(AT)) dut (
        .clk         (clk),
        .resetN      (resetN),
        .enable      (enable),
        .freqTarget  (freqTarget),
        .scaleTarget (scaleTarget),
        .clrErr      (clrErr),
        .busy        (busy),
        .ackErr      (ackErr),
        .sampleValid (sampleValid),
        .lfo         (bus.master)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int last_strobe = 0;
    bit exp_err = 1'b0;
    int exp_q[$];

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_strobe(output int s);
        int n;
        n = 0;
        s = -1;
        while (n < TD + 20) begin
            step();
            n++;
            if (bus.fifoUpdate === 1'b1) begin
                s = cyc;
                break;
            end
        end
        checks++;
        if (s < 0) begin
            failures++;
            $display("FAIL strobe_timeout: no fifoUpdate in %0d cycles, required one", TD + 20);
            s = cyc;
        end else if (s - last_strobe != TD) begin
            failures++;
            $display("FAIL strobe_period: got %0d cycles, required %0d", s - last_strobe, TD);
        end
        last_strobe = s;
    endtask

    // One sample period: expected sampleValid cycles go to exp_q on the strobe and are popped on output.
    task automatic sample(input bit ack, input bit clr_at_to, input logic [3:0] pf, input logic [3:0] ps,
                          input logic [3:0] ef, input logic [3:0] es, input logic eb);
        int s, bnd, e;
        wait_strobe(s);
        bnd = ack ? s + 4 : s + AT + 1;
        if (ack) exp_q.push_back(s + 4);
        for (int k = 1; k <= 10; k++) begin
            step();
            bus.newValFlag = ack && (k == 3);
            clrErr = clr_at_to && (k == AT);
            if (!ack && k == AT + 1) exp_err = 1'b1;
            checks++;
            if (ackErr !== exp_err) begin
                failures++;
                $display("FAIL ack_err at strobe+%0d: got %b, required %b", k, ackErr, exp_err);
            end
            if (sampleValid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL spurious_valid at strobe+%0d: got 1, required 0", k);
                end else begin
                    e = exp_q.pop_front();
                    if (cyc != e) begin
                        failures++;
                        $display("FAIL valid_time: got strobe+%0d, required strobe+%0d", cyc - s, e - s);
                    end
                end
            end
            if (k == 3) begin
                checks++;
                if (bus.lfoFreq !== pf || bus.lfoScale !== ps) begin
                    failures++;
                    $display("FAIL mid_sample_settings: got %0d/%0d, required %0d/%0d",
                             bus.lfoFreq, bus.lfoScale, pf, ps);
                end
            end
            if (cyc == bnd) begin
                checks++;
                if (bus.lfoFreq !== ef || bus.lfoScale !== es || busy !== eb) begin
                    failures++;
                    $display("FAIL boundary_settings: got %0d/%0d busy=%b, required %0d/%0d busy=%b",
                             bus.lfoFreq, bus.lfoScale, busy, ef, es, eb);
                end
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL missing_valid: got none, required %0d pulse(s)", exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        resetN = 1'b0; enable = 1'b0; clrErr = 1'b0; bus.newValFlag = 1'b0;
        freqTarget = 4'd3; scaleTarget = 4'd15;
        repeat (3) step();
        checks++;
        if (bus.lfoReset !== 1'b1 || bus.fifoUpdate !== 1'b0 || bus.lfoFreq !== 4'd0 ||
            bus.lfoScale !== 4'd0 || busy !== 1'b0 || ackErr !== 1'b0 || sampleValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_state: got rst=%b upd=%b f=%0d s=%0d busy=%b err=%b val=%b, required 1 0 0 0 0 0 0",
                     bus.lfoReset, bus.fifoUpdate, bus.lfoFreq, bus.lfoScale, busy, ackErr, sampleValid);
        end
    endtask

    task automatic test_startup();
        int c0;
        enable = 1'b1;
        resetN = 1'b1;
        c0 = cyc;
        for (int k = 1; k <= 6; k++) begin
            step();
            checks++;
            if (bus.lfoReset !== 1'b1 || bus.fifoUpdate !== 1'b0) begin
                failures++;
                $display("FAIL startup_reset c%0d: got rst=%b upd=%b, required 1 0", k, bus.lfoReset, bus.fifoUpdate);
            end
        end
        step();
        checks++;
        if (bus.lfoReset !== 1'b0 || bus.lfoFreq !== 4'd3 || bus.lfoScale !== 4'd15) begin
            failures++;
            $display("FAIL run_entry: got rst=%b f=%0d s=%0d, required 0 3 15", bus.lfoReset, bus.lfoFreq, bus.lfoScale);
        end
        last_strobe = c0 + 6;
    endtask

    task automatic test_ack();
        for (int n = 0; n < 20; n++) sample(1'b1, 1'b0, 4'd3, 4'd15, 4'd3, 4'd15, 1'b0);
    endtask

    task automatic test_timeout();
        sample(1'b0, 1'b0, 4'd3, 4'd15, 4'd3, 4'd15, 1'b0);
        clrErr = 1'b1;
        step();
        clrErr = 1'b0;
        exp_err = 1'b0;
        checks++;
        if (ackErr !== 1'b0) begin
            failures++;
            $display("FAIL clr_err: got %b, required 0", ackErr);
        end
        sample(1'b0, 1'b1, 4'd3, 4'd15, 4'd3, 4'd15, 1'b0);
    endtask

`ifdef LFO_CTRL_GLIDE_EN
    task automatic test_glide();
        logic [3:0] pf, ef;
        freqTarget = 4'd13;
        for (int n = 1; n <= 40; n++) begin
            pf = 4'(3 + (n - 1) / GT);
            ef = 4'(3 + n / GT);
            sample(1'b1, 1'b0, pf, 4'd15, ef, 4'd15, ef != 4'd13);
        end
    endtask
`else
    task automatic test_direct_load();
        scaleTarget = 4'd8;
        sample(1'b1, 1'b0, 4'd3, 4'd15, 4'd3, 4'd8, 1'b0);
    endtask
`endif

    task automatic test_enable_drop_reset();
        int s;
        logic [3:0] f0, s0;
        f0 = bus.lfoFreq;
        s0 = bus.lfoScale;
        wait_strobe(s);
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) enable = 1'b0;
            bus.newValFlag = (k == 3);
            if (k == 3) begin
                checks++;
                if (bus.lfoReset !== 1'b0) begin
                    failures++;
                    $display("FAIL ack_before_idle: got rst=%b, required 0", bus.lfoReset);
                end
            end
            if (k == 4) begin
                checks++;
                if (sampleValid !== 1'b1 || bus.lfoReset !== 1'b1) begin
                    failures++;
                    $display("FAIL drop_to_idle: got val=%b rst=%b, required 1 1", sampleValid, bus.lfoReset);
                end
            end
        end
        checks++;
        if (bus.lfoFreq !== f0 || bus.lfoScale !== s0 || ackErr !== 1'b1) begin
            failures++;
            $display("FAIL idle_retain: got f=%0d s=%0d err=%b, required %0d %0d 1", bus.lfoFreq, bus.lfoScale, ackErr, f0, s0);
        end
        enable = 1'b1;
        repeat (4) step();
        checks++;
        if (bus.lfoReset !== 1'b1 || bus.fifoUpdate !== 1'b0) begin
            failures++;
            $display("FAIL reinit: got rst=%b upd=%b, required 1 0", bus.lfoReset, bus.fifoUpdate);
        end
        #2 resetN = 1'b0;
        #1;
        checks++;
        if (bus.lfoReset !== 1'b1 || bus.fifoUpdate !== 1'b0 || bus.lfoFreq !== 4'd0 ||
            bus.lfoScale !== 4'd0 || busy !== 1'b0 || ackErr !== 1'b0 || sampleValid !== 1'b0) begin
            failures++;
            $display("FAIL async_reset: got rst=%b upd=%b f=%0d s=%0d busy=%b err=%b val=%b, required 1 0 0 0 0 0 0",
                     bus.lfoReset, bus.fifoUpdate, bus.lfoFreq, bus.lfoScale, busy, ackErr, sampleValid);
        end
        step();
        resetN = 1'b1;
    endtask

    initial begin
        test_reset();
        test_startup();
        test_ack();
        test_timeout();
`ifdef LFO_CTRL_GLIDE_EN
        test_glide();
`else
        test_direct_load();
`endif
        test_enable_drop_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/lfo_ctrl.md
LFO_CTRL -- requirements
Module: lfo_ctrl

Interface
REQ-001 SHALL have parameter TICK_DIV, default 136, meaning clk cycles per audio sample tick (6 MHz / 44.1 kHz); legal range 16..4095.
REQ-002 SHALL have parameter GLIDE_TICKS, default 64, meaning sample ticks between successive one-step parameter changes.
REQ-003 SHALL have parameter ACK_TIMEOUT, default 8, meaning max clk cycles to wait for LFO acknowledge; SHALL be < TICK_DIV-2.
REQ-004 SHALL use one clock and an asynchronous, active-low reset: clk in 1 system clock (6 MHz); resetN in 1 async active-low reset.
REQ-005 enable in 1: run request (async, from switch).
REQ-006 freqTarget in 4, scaleTarget in 4: requested LFO frequency/scale codes (async, from switches).
REQ-007 clrErr in 1: clears ackErr (synchronous to clk).
REQ-008 newValFlag in 1: LFO new-sample acknowledge pulse.
REQ-009 fifoUpdate out 1: one-cycle sample strobe to LFO; lfoReset out 1: active-high reset to LFO.
REQ-010 lfoFreq out 4, lfoScale out 4: applied LFO settings; busy out 1: glide in progress; ackErr out 1: sticky timeout flag; sampleValid out 1: one-cycle pulse on acknowledged sample.

Function
REQ-011 enable, freqTarget, scaleTarget SHALL pass through 2-flop synchronizers; all decisions use synchronized values (2-cycle input latency).
REQ-012 FSM states IDLE, INIT, RUN, WAIT_ACK; no other reachable state.
REQ-013 IDLE: lfoReset=1, fifoUpdate=0, tick counter held 0; go INIT when synced enable=1.
REQ-014 INIT: lfoReset=1 for exactly 4 cycles; lfoFreq/lfoScale loaded directly with synced targets on first INIT cycle; then RUN with counter=0.
REQ-015 RUN/WAIT_ACK: lfoReset=0; tick counter counts 0..TICK_DIV-1 and wraps, free-running independent of acknowledge.
REQ-016 fifoUpdate SHALL be high for exactly the cycle the counter equals TICK_DIV-1; first strobe TICK_DIV cycles after entering RUN; strobe period exactly TICK_DIV.
REQ-017 On strobe, RUN->WAIT_ACK with ack timer cleared.
REQ-018 WAIT_ACK: newValFlag=1 within ACK_TIMEOUT cycles -> sampleValid pulse next cycle, go RUN; no ack by ACK_TIMEOUT -> ackErr=1, go RUN, no sampleValid.
REQ-019 newValFlag while in RUN/IDLE/INIT SHALL be ignored.
REQ-020 lfoFreq/lfoScale SHALL change only on the WAIT_ACK->RUN transition cycle (sample boundary), never mid-sample.
REQ-021 ackErr set and clrErr in same cycle: set wins.
REQ-022 enable deasserted in RUN: go IDLE next cycle; in WAIT_ACK: complete ack/timeout first, then IDLE; lfoFreq/lfoScale retain values in IDLE.
REQ-023 enable re-asserted: full INIT sequence repeats.

Reset
REQ-024 resetN=0 SHALL immediately force: state IDLE, counters 0, glide count 0, synchronizers 0, fifoUpdate 0, lfoReset 1, lfoFreq 0, lfoScale 0, busy 0, ackErr 0, sampleValid 0.
REQ-025 Reset mid-WAIT_ACK SHALL abandon the pending acknowledge without setting ackErr.
REQ-026 Reset deassertion SHALL NOT produce a strobe for at least 2+4+TICK_DIV cycles.

Configuration
REQ-027 Macro LFO_CTRL_GLIDE_EN defined: at each sample boundary a glide counter increments; when it reaches GLIDE_TICKS it clears and lfoFreq and lfoScale each step +/-1 toward their synced targets (independently, saturating at target); busy=1 while either differs from target.
REQ-028 Macro undefined: at each sample boundary lfoFreq/lfoScale load synced targets directly; busy constant 0; no glide counter logic.

Verification
REQ-029 Reset, enable=1 at t0 -> lfoReset high through 2 sync + 4 INIT cycles, first fifoUpdate exactly TICK_DIV=136 cycles after RUN entry, then every 136 cycles.
REQ-030 Model acks newValFlag 3 cycles after each strobe -> sampleValid pulse 4 cycles after strobe, ackErr stays 0 over 20 samples.
REQ-031 No acknowledge -> ackErr=1 9 cycles after strobe, strobe period still 136; clrErr pulse coinciding with next timeout -> ackErr remains 1.
REQ-032 GLIDE_EN, lfoFreq=3, freqTarget 3->13, GLIDE_TICKS=4 -> lfoFreq increments one step per 4 acked samples, reaches 13 after 40 samples, busy drops same cycle; changes only on ack boundaries.
REQ-033 No GLIDE_EN, scaleTarget 15->8 -> lfoScale=8 at first sample boundary after 2-cycle sync; busy=0 throughout.
REQ-034 enable dropped during WAIT_ACK, then resetN pulsed mid-INIT -> ack finishes before IDLE; reset forces all REQ-024 values asynchronously, ackErr=0.
